// File: rtl/int_sum_accel.sv
// int_sum_accel: memory-mapped integer-sum accelerator.
// Streams COUNT consecutive 32-bit words from memory, accumulates them as
// two's-complement integers (wrapping), writes the sum to a result address
// and pulses done_o. Up to MAX_OUT reads are kept in flight.
//
// Request handshake: a request (mem_valid_o with mem_addr_o/mem_wdata_o/
// mem_wstrb_o) is transferred on a rising clk_i edge where mem_valid_o and
// mem_ready_i are both high. Once mem_valid_o is raised, it and the request
// fields are held unchanged until that transfer. mem_wstrb_o == 0 marks a
// read; reads return data in request order via mem_rvalid_i, writes return
// nothing.
module int_sum_accel #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = 4,
    parameter int CNT_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [ADDR_W-1:0] res_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    input  logic              mem_ready_i
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] res_addr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  returned;
    logic [OUT_W-1:0]  outstanding;
    logic [DATA_W-1:0] acc;

    logic              rd_accept;
    logic              rd_return;
    logic [CNT_W-1:0]  issued_nx;
    logic [CNT_W-1:0]  returned_nx;
    logic [OUT_W-1:0]  outstanding_nx;
    logic [DATA_W-1:0] acc_nx;
    logic              can_issue;
    logic [ADDR_W-1:0] rd_addr_nx;

    // Next-cycle counter/accumulator values; a return is only counted while
    // reads are pending in READ/DRAIN, so stale or stray responses are dropped.
    always_comb begin
        rd_accept      = mem_valid_o && mem_ready_i && (state_q == S_READ);
        rd_return      = mem_rvalid_i && (outstanding != '0) &&
                         ((state_q == S_READ) || (state_q == S_DRAIN));
        issued_nx      = issued + {{(CNT_W-1){1'b0}}, rd_accept};
        returned_nx    = returned + {{(CNT_W-1){1'b0}}, rd_return};
        outstanding_nx = outstanding + {{(OUT_W-1){1'b0}}, rd_accept}
                                     - {{(OUT_W-1){1'b0}}, rd_return};
        acc_nx         = rd_return ? (acc + mem_rdata_i) : acc;
        can_issue      = (issued_nx < count) && (outstanding_nx < MAX_OUT_V);
        rd_addr_nx     = base + ADDR_W'({issued_nx, 2'b00});
    end

    // Control FSM with registered bus and status outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= S_IDLE;
            base        <= '0;
            res_addr    <= '0;
            count       <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            acc         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base        <= base_addr_i;
                        res_addr    <= res_addr_i;
                        count       <= count_i;
                        issued      <= '0;
                        returned    <= '0;
                        outstanding <= '0;
                        acc         <= '0;
                        busy_o      <= 1'b1;
                        mem_valid_o <= 1'b1;
                        mem_wdata_o <= '0;
                        if (count_i != '0) begin
                            // First read goes out straight away.
                            state_q     <= S_READ;
                            mem_addr_o  <= base_addr_i;
                            mem_wstrb_o <= '0;
                        end else begin
                            // Empty sum: write zero without reading.
                            state_q     <= S_WRITE;
                            mem_addr_o  <= res_addr_i;
                            mem_wstrb_o <= '1;
                        end
                    end
                end

                S_READ: begin
                    issued      <= issued_nx;
                    returned    <= returned_nx;
                    outstanding <= outstanding_nx;
                    acc         <= acc_nx;
                    // Only replace the request once the current one is gone.
                    if (!mem_valid_o || mem_ready_i) begin
                        mem_valid_o <= can_issue;
                        if (can_issue) begin
                            mem_addr_o <= rd_addr_nx;
                        end
                        if (issued_nx == count) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    returned    <= returned_nx;
                    outstanding <= outstanding_nx;
                    acc         <= acc_nx;
                    if (returned_nx == count) begin
                        state_q     <= S_WRITE;
                        mem_valid_o <= 1'b1;
                        mem_addr_o  <= res_addr;
                        mem_wdata_o <= acc_nx;
                        mem_wstrb_o <= '1;
                    end
                end

                S_WRITE: begin
                    if (mem_ready_i) begin
                        state_q     <= S_DONE;
                        mem_valid_o <= 1'b0;
                        mem_wdata_o <= '0;
                        mem_wstrb_o <= '0;
                        result_o    <= acc;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                    end
                end

                S_DONE: begin
                    done_o  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_sum_accel.sv
// Testbench for int_sum_accel: a behavioural memory/bus responder with
// configurable ready pattern and read latency, plus a reference sum computed
// directly from the memory contents.
module tb_int_sum_accel;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int CNT_W   = 8;
    localparam int MAX_OUT = 4;

    logic              clk_i;
    logic              arst_i;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [CNT_W-1:0]  count_i;
    logic [ADDR_W-1:0] res_addr_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;
    logic              mem_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [STRB_W-1:0] mem_wstrb_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_rvalid_i;
    logic              mem_ready_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Bus responder state and logs.
    int          cyc;
    int          lat;
    int          ready_mode;
    int          due_q[$];
    logic [31:0] rdata_q[$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rd_log[$];
    int          rd_cyc_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [3:0]  wr_strb_log[$];
    logic [31:0] exp_q[$];
    int          done_cnt;
    int          done_busy_errs;
    int          stall_errs;
    int          rd_wdata_errs;
    int          tb_out;
    int          max_out;
    logic        prev_pending;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_wstrb;

    int_sum_accel #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .CNT_W  (CNT_W),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .res_addr_i  (res_addr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .mem_valid_o (mem_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_ready_i (mem_ready_i)
    );

    // Clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Bus responder: drives ready/rvalid on the falling edge for the next
    // rising edge, logs transfers and returns read data in order after lat cycles.
    initial begin
        cyc = 0; lat = 2; ready_mode = 0;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        prev_pending = 1'b0; prev_addr = '0; prev_wdata = '0; prev_wstrb = '0;
        tb_out = 0; max_out = 0; done_cnt = 0; done_busy_errs = 0;
        stall_errs = 0; rd_wdata_errs = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            case (ready_mode)
                0:       mem_ready_i = 1'b1;
                1:       mem_ready_i = ~mem_ready_i;
                2:       mem_ready_i = 1'($urandom_range(0, 1));
                default: mem_ready_i = 1'b0;
            endcase
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rdata_q.pop_front();
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = $urandom;
            end
            if (prev_pending && (mem_valid_o !== 1'b1 || mem_addr_o !== prev_addr ||
                                 mem_wdata_o !== prev_wdata || mem_wstrb_o !== prev_wstrb))
                stall_errs++;
            if (done_o === 1'b1) begin
                done_cnt++;
                if (busy_o !== 1'b0) done_busy_errs++;
            end
            if (mem_valid_o === 1'b1 && mem_ready_i) begin
                prev_pending = 1'b0;
                if (mem_wstrb_o == '0) begin
                    rd_log.push_back(mem_addr_o);
                    rd_cyc_log.push_back(cyc);
                    if (mem_wdata_o !== '0) rd_wdata_errs++;
                    due_q.push_back(cyc + lat);
                    rdata_q.push_back(mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o]
                                                                   : 32'hDEAD_BEEF);
                    tb_out++;
                end else begin
                    wr_addr_log.push_back(mem_addr_o);
                    wr_data_log.push_back(mem_wdata_o);
                    wr_strb_log.push_back(mem_wstrb_o);
                end
            end else begin
                prev_pending = (mem_valid_o === 1'b1);
                prev_addr    = mem_addr_o;
                prev_wdata   = mem_wdata_o;
                prev_wstrb   = mem_wstrb_o;
            end
            if (mem_rvalid_i) tb_out--;
            if (tb_out > max_out) max_out = tb_out;
        end
    end

    task automatic clear_logs();
        rd_log.delete(); rd_cyc_log.delete();
        wr_addr_log.delete(); wr_data_log.delete(); wr_strb_log.delete();
        done_cnt = 0; done_busy_errs = 0; stall_errs = 0; rd_wdata_errs = 0; max_out = 0;
    endtask

    // One complete accumulation; reference: reads at base+4*i, sum of words mod 2^32.
    task automatic run_sum(input string name, input logic [31:0] base, input logic [31:0] res,
                           input int cnt, input int l, input int rmode, input int busy_at);
        logic [31:0] exp_sum;
        logic [31:0] a;
        int          bad;
        int          bad_idx;
        int          waited;
        exp_sum = '0;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            a = base + 32'(4 * i);
            exp_q.push_back(a);
            exp_sum = exp_sum + mem_model[a];
        end
        clear_logs();
        lat = l; ready_mode = rmode;
        base_addr_i = base; count_i = 8'(cnt); res_addr_i = res; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        base_addr_i = $urandom; count_i = 8'($urandom); res_addr_i = $urandom;
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, busy_o);
        else n_pass++;
        if (busy_at > 0) begin
            repeat (busy_at - 1) @(negedge clk_i);
            base_addr_i = base + 32'h1000; count_i = 8'd3; res_addr_i = res + 32'h40;
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 3000) begin
            @(negedge clk_i);
            waited++;
        end
        repeat (6) @(negedge clk_i);

        n_checks++;
        if (waited >= 3000) $display("FAIL %s done_timeout: waited %0d cycles, expected done", name, waited);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        else n_pass++;
        n_checks++;
        if (done_busy_errs != 0) $display("FAIL %s busy_during_done: got %0d cycles expected 0", name, done_busy_errs);
        else n_pass++;
        n_checks++;
        if (rd_log.size() != cnt) $display("FAIL %s read_count: got %0d expected %0d", name, rd_log.size(), cnt);
        else n_pass++;
        bad = 0; bad_idx = -1;
        for (int i = 0; i < rd_log.size() && i < exp_q.size(); i++) begin
            if (rd_log[i] !== exp_q[i]) begin
                bad++;
                if (bad_idx < 0) bad_idx = i;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL %s read_addr: index %0d got %h expected %h (%0d wrong)",
                               name, bad_idx, rd_log[bad_idx], exp_q[bad_idx], bad);
        else n_pass++;
        n_checks++;
        if (wr_addr_log.size() != 1) $display("FAIL %s write_count: got %0d expected 1", name, wr_addr_log.size());
        else n_pass++;
        if (wr_addr_log.size() >= 1) begin
            n_checks++;
            if (wr_addr_log[0] !== res) $display("FAIL %s write_addr: got %h expected %h", name, wr_addr_log[0], res);
            else n_pass++;
            n_checks++;
            if (wr_data_log[0] !== exp_sum) $display("FAIL %s write_data: got %h expected %h", name, wr_data_log[0], exp_sum);
            else n_pass++;
            n_checks++;
            if (wr_strb_log[0] !== 4'hF) $display("FAIL %s write_strb: got %h expected f", name, wr_strb_log[0]);
            else n_pass++;
        end
        n_checks++;
        if (result_o !== exp_sum) $display("FAIL %s result: got %h expected %h", name, result_o, exp_sum);
        else n_pass++;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL %s busy_after_done: got %b expected 0", name, busy_o);
        else n_pass++;
        n_checks++;
        if (stall_errs != 0) $display("FAIL %s request_stability: got %0d changes expected 0", name, stall_errs);
        else n_pass++;
        n_checks++;
        if (rd_wdata_errs != 0) $display("FAIL %s read_wdata_zero: got %0d nonzero expected 0", name, rd_wdata_errs);
        else n_pass++;
        n_checks++;
        if (max_out > MAX_OUT) $display("FAIL %s max_outstanding: got %0d expected <= %0d", name, max_out, MAX_OUT);
        else n_pass++;
    endtask

    task automatic load_seq(input logic [31:0] base, input int cnt);
        mem_model.delete();
        for (int i = 0; i < cnt; i++) mem_model[base + 32'(4 * i)] = 32'(i + 1);
    endtask

    task automatic test_reset();
        arst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_valid_o !== 1'b0)
            $display("FAIL reset_ctrl: got busy=%b done=%b valid=%b expected 0 0 0", busy_o, done_o, mem_valid_o);
        else n_pass++;
        n_checks++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0 || mem_wstrb_o !== '0)
            $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%h expected zeros", mem_addr_o, mem_wdata_o, mem_wstrb_o);
        else n_pass++;
        n_checks++;
        if (result_o !== '0) $display("FAIL reset_result: got %h expected 0", result_o);
        else n_pass++;
        arst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        int diff;
        load_seq(32'h100, 8);
        run_sum("basic", 32'h100, 32'h200, 8, 2, 0, 0);
        n_checks++;
        if (result_o !== 32'd36) $display("FAIL basic_result36: got %0d expected 36", result_o);
        else n_pass++;
        diff = (rd_cyc_log.size() >= 8) ? (rd_cyc_log[7] - rd_cyc_log[0]) : -1;
        n_checks++;
        if (diff != 7) $display("FAIL basic_back_to_back: got span %0d expected 7", diff);
        else n_pass++;
    endtask

    task automatic test_stall();
        load_seq(32'h100, 8);
        run_sum("stall", 32'h100, 32'h204, 8, 2, 1, 0);
        n_checks++;
        if (result_o !== 32'd36) $display("FAIL stall_result36: got %0d expected 36", result_o);
        else n_pass++;
    endtask

    task automatic test_outstanding();
        int diff;
        load_seq(32'h100, 8);
        run_sum("outstanding", 32'h100, 32'h208, 8, 10, 0, 0);
        n_checks++;
        if (max_out != MAX_OUT) $display("FAIL outstanding_fill: got %0d expected %0d", max_out, MAX_OUT);
        else n_pass++;
        diff = (rd_cyc_log.size() >= 5) ? (rd_cyc_log[4] - rd_cyc_log[0]) : -1;
        n_checks++;
        if (diff != 11) $display("FAIL outstanding_resume: got %0d cycles expected 11", diff);
        else n_pass++;
    endtask

    task automatic test_overflow();
        mem_model.delete();
        mem_model[32'h400] = 32'h7FFF_FFFF;
        mem_model[32'h404] = 32'h0000_0001;
        mem_model[32'h408] = 32'hFFFF_FFFF;
        run_sum("overflow", 32'h400, 32'h480, 3, 3, 0, 0);
        n_checks++;
        if (result_o !== 32'h7FFF_FFFF) $display("FAIL overflow_wrap: got %h expected 7fffffff", result_o);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        mem_model.delete();
        run_sum("zero", 32'h100, 32'h20C, 0, 2, 0, 0);
        n_checks++;
        if (result_o !== 32'h0) $display("FAIL zero_result: got %h expected 0", result_o);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        mem_model.delete();
        for (int i = 0; i < 8; i++) mem_model[32'h300 + 32'(4 * i)] = $urandom;
        run_sum("busy_start", 32'h300, 32'h380, 8, 4, 0, 2);
    endtask

    task automatic test_reset_mid();
        int waited;
        mem_model.delete();
        for (int i = 0; i < 8; i++) mem_model[32'h500 + 32'(4 * i)] = $urandom;
        clear_logs();
        lat = 10; ready_mode = 0;
        base_addr_i = 32'h500; count_i = 8'd8; res_addr_i = 32'h600; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        waited = 0;
        while (rd_log.size() < 2 && waited < 50) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        arst_i = 1'b1;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || mem_valid_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL midreset_async: got busy=%b valid=%b done=%b expected 0 0 0", busy_o, mem_valid_o, done_o);
        else n_pass++;
        n_checks++;
        if (tb_out != 2) $display("FAIL midreset_inflight: got %0d outstanding expected 2", tb_out);
        else n_pass++;
        @(negedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
        waited = 0;
        while (due_q.size() > 0 && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || mem_valid_o !== 1'b0 || done_cnt != 0)
            $display("FAIL midreset_late_rvalid: got busy=%b valid=%b done_pulses=%0d expected 0 0 0",
                     busy_o, mem_valid_o, done_cnt);
        else n_pass++;
        n_checks++;
        if (rd_log.size() != 2) $display("FAIL midreset_reads: got %0d reads expected 2", rd_log.size());
        else n_pass++;
        n_checks++;
        if (result_o !== '0) $display("FAIL midreset_result: got %h expected 0", result_o);
        else n_pass++;
        run_sum("after_reset", 32'h500, 32'h600, 8, 3, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] base;
        int          cnt;
        for (int it = 0; it < 6; it++) begin
            cnt  = $urandom_range(0, 20);
            base = 32'($urandom_range(0, 4095)) << 2;
            mem_model.delete();
            for (int i = 0; i < cnt; i++) mem_model[base + 32'(4 * i)] = $urandom;
            run_sum($sformatf("rand%0d", it), base, 32'h8000 + 32'(4 * it), cnt,
                    $urandom_range(1, 8), 2, 0);
        end
    endtask

    initial begin
        arst_i = 1'b1; start_i = 1'b0;
        base_addr_i = '0; count_i = '0; res_addr_i = '0;
        test_reset();
        test_basic();
        test_stall();
        test_outstanding();
        test_overflow();
        test_zero_count();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
